// File: rtl/lcd_instr_sequencer.sv
// Spartan-3E character LCD sequencer: power-on nibble init, BRAM-driven
// command/character fetch, timed 4-bit writes and periodic refresh.
module lcd_instr_sequencer #(
    parameter int POWERON_CYC = 750000,
    parameter int E_CYC       = 12,
    parameter int NIB_GAP_CYC = 50,
    parameter int CMD_CYC     = 2000,
    parameter int INIT1_CYC   = 205000,
    parameter int INIT2_CYC   = 5000,
    parameter int CLEAR_CYC   = 82000,
    parameter int REFRESH_CYC = 50000000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [10:0] ROM_ADDR,
    output logic        ROM_EN,
    input  logic [7:0]  ROM_DO,
    input  logic        UPDATE,
    output logic [3:0]  LCD_DB,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        SF_CE0,
    output logic        INIT_DONE,
    output logic        FRAME_DONE
);

    localparam logic [31:0] PWR_L   = 32'(POWERON_CYC - 1);
    localparam logic [31:0] E_L     = 32'(E_CYC - 1);
    localparam logic [31:0] GAP_L   = 32'(NIB_GAP_CYC - 1);
    localparam logic [31:0] CMD_L   = 32'(CMD_CYC - 1);
    localparam logic [31:0] INIT1_L = 32'(INIT1_CYC - 1);
    localparam logic [31:0] INIT2_L = 32'(INIT2_CYC - 1);
    localparam logic [31:0] CLEAR_L = 32'(CLEAR_CYC - 1);
    localparam logic [31:0] REF_L   = 32'(REFRESH_CYC - 1);

    typedef enum logic [3:0] {
        PWR_WAIT, FETCH, CAPTURE, SETUP, E_HIGH,
        HOLD, GAP, POST, REFRESH_WAIT
    } state_t;

    typedef enum logic [1:0] {
        CTX_INIT, CTX_CMD, CTX_LINE, CTX_CHAR
    } ctx_t;

    state_t      state_q, state_d;
    ctx_t        ctx_q, ctx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic        nib_q, nib_d;
    logic [1:0]  idx_q, idx_d;
    logic [10:0] rom_addr_q, rom_addr_d;
    logic        rom_en_q, rom_en_d;
    logic [3:0]  db_q, db_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;
    logic        go_line;
    logic [7:0]  line_byte;
    logic        cnt_zero;
    logic [31:0] cnt_dec;

    assign cnt_zero = (cnt_q == 32'd0);
    assign cnt_dec  = cnt_q - 32'd1;

    always_comb begin
        state_d      = state_q;
        ctx_d        = ctx_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        nib_d        = nib_q;
        idx_d        = idx_q;
        db_d         = db_q;
        rs_d         = rs_q;
        rom_addr_d   = rom_addr_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        go_line      = 1'b0;
        line_byte    = 8'h80;
        unique case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_L) begin
                    state_d = SETUP;
                    ctx_d   = CTX_INIT;
                    idx_d   = 2'd0;
                    db_d    = 4'h3;
                    rs_d    = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                byte_d = ROM_DO;
                // A zero command byte is a pure delay slot.
                if (ctx_q == CTX_CMD && ROM_DO == 8'h00) begin
                    state_d = POST;
                    cnt_d   = CLEAR_L;
                end else begin
                    state_d = SETUP;
                    nib_d   = 1'b0;
                    db_d    = ROM_DO[7:4];
                    rs_d    = (ctx_q == CTX_CHAR);
                end
            end
            SETUP: begin
                state_d = E_HIGH;
                cnt_d   = E_L;
            end
            E_HIGH: begin
                if (cnt_zero) state_d = HOLD;
                else cnt_d = cnt_dec;
            end
            HOLD: begin
                state_d = POST;
                if (ctx_q == CTX_INIT) begin
                    cnt_d = (idx_q == 2'd0) ? INIT1_L :
                            (idx_q == 2'd1) ? INIT2_L : CMD_L;
                end else if (!nib_q) begin
                    state_d = GAP;
                    cnt_d   = GAP_L;
                end else if (byte_q == 8'h01 && !rs_q) begin
                    cnt_d = CLEAR_L;
                end else begin
                    cnt_d = CMD_L;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = SETUP;
                    nib_d   = 1'b1;
                    db_d    = byte_q[3:0];
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            POST: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else begin
                    unique case (ctx_q)
                        CTX_INIT: begin
                            if (idx_q == 2'd3) begin
                                ctx_d   = CTX_CMD;
                                addr_d  = 6'd0;
                                state_d = FETCH;
                            end else begin
                                idx_d   = idx_q + 2'd1;
                                state_d = SETUP;
                                db_d    = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                            end
                        end
                        CTX_CMD: begin
                            if (addr_q == 6'd4) begin
                                init_done_d = 1'b1;
                                go_line     = 1'b1;
                                addr_d      = 6'd5;
                            end else begin
                                addr_d  = addr_q + 6'd1;
                                state_d = FETCH;
                            end
                        end
                        CTX_LINE: begin
                            ctx_d   = CTX_CHAR;
                            state_d = FETCH;
                        end
                        default: begin
                            if (addr_q == 6'd20) begin
                                go_line   = 1'b1;
                                line_byte = 8'hC0;
                                addr_d    = 6'd21;
                            end else if (addr_q == 6'd36) begin
                                frame_done_d = 1'b1;
                                state_d      = REFRESH_WAIT;
                                cnt_d        = REF_L;
                            end else begin
                                addr_d  = addr_q + 6'd1;
                                state_d = FETCH;
                            end
                        end
                    endcase
                end
            end
            REFRESH_WAIT: begin
                if (UPDATE || cnt_zero) begin
                    go_line = 1'b1;
                    addr_d  = 6'd5;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
        if (go_line) begin
            state_d = SETUP;
            ctx_d   = CTX_LINE;
            byte_d  = line_byte;
            nib_d   = 1'b0;
            db_d    = line_byte[7:4];
            rs_d    = 1'b0;
        end
        rom_en_d = (state_d == FETCH);
        if (rom_en_d) rom_addr_d = {5'd0, addr_d};
        e_d = (state_d == E_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= PWR_WAIT;
            ctx_q        <= CTX_INIT;
            cnt_q        <= 32'd0;
            addr_q       <= 6'd0;
            byte_q       <= 8'd0;
            nib_q        <= 1'b0;
            idx_q        <= 2'd0;
            rom_addr_q   <= 11'd0;
            rom_en_q     <= 1'b0;
            db_q         <= 4'd0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            nib_q        <= nib_d;
            idx_q        <= idx_d;
            rom_addr_q   <= rom_addr_d;
            rom_en_q     <= rom_en_d;
            db_q         <= db_d;
            e_q          <= e_d;
            rs_q         <= rs_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ROM_ADDR   = rom_addr_q;
    assign ROM_EN     = rom_en_q;
    assign LCD_DB     = db_q;
    assign LCD_E      = e_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign SF_CE0     = 1'b1;
    assign INIT_DONE  = init_done_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_lcd_instr_sequencer.sv
// Scoreboard bench for lcd_instr_sequencer: a timeline model predicts every
// LCD strobe, fetch and status pulse; a negedge monitor checks them.
module tb_lcd_instr_sequencer;

    localparam int PW = 20;
    localparam int EC = 2;
    localparam int GC = 3;
    localparam int CC = 5;
    localparam int I1 = 10;
    localparam int I2 = 8;
    localparam int CL = 15;
    localparam int RF = 100;

    logic        clk = 1'b0;
    logic        RESET;
    logic        UPDATE;
    logic [10:0] ROM_ADDR;
    logic        ROM_EN;
    logic [7:0]  rom_do = 8'h00;
    logic [3:0]  LCD_DB;
    logic        LCD_E, LCD_RS, LCD_RW, SF_CE0, INIT_DONE, FRAME_DONE;

    lcd_instr_sequencer #(
        .POWERON_CYC(PW), .E_CYC(EC), .NIB_GAP_CYC(GC), .CMD_CYC(CC),
        .INIT1_CYC(I1), .INIT2_CYC(I2), .CLEAR_CYC(CL), .REFRESH_CYC(RF)
    ) dut (
        .CLK(clk), .RESET(RESET), .ROM_ADDR(ROM_ADDR), .ROM_EN(ROM_EN),
        .ROM_DO(rom_do), .UPDATE(UPDATE), .LCD_DB(LCD_DB), .LCD_E(LCD_E),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .SF_CE0(SF_CE0),
        .INIT_DONE(INIT_DONE), .FRAME_DONE(FRAME_DONE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rom [0:63];
    always @(posedge clk) if (ROM_EN) rom_do <= rom[ROM_ADDR[5:0]];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct { int c; int v; int rs; } ev_t;
    ev_t q_e[$];
    ev_t q_f[$];
    int  q_id[$];
    int  q_fd[$];
    int  t, cut, last_hi;

    function automatic void push_e(input int c, input int v, input int rs);
        ev_t e;
        if (c <= cut) begin
            e.c = c; e.v = v; e.rs = rs;
            q_e.push_back(e);
        end
    endfunction

    function automatic void fetch(input int a);
        ev_t e;
        if (t <= cut) begin
            e.c = t; e.v = a; e.rs = 0;
            q_f.push_back(e);
        end
        t += 2;
    endfunction

    function automatic void nib1(input int v, input int post);
        int r;
        r = t + 1;
        push_e(r, v, 0);
        t = r + EC + 1 + post;
    endfunction

    function automatic void send_byte(input int b, input int rs);
        int hi, lo;
        hi = t + 1;
        lo = hi + EC + 2 + GC;
        push_e(hi, b / 16, rs);
        push_e(lo, b % 16, rs);
        last_hi = hi;
        t = lo + EC + 1 + ((b == 1 && rs == 0) ? CL : CC);
    endfunction

    function automatic void frame(output int fd, output int g);
        g = 0;
        send_byte(128, 0);
        for (int a = 5; a <= 36; a++) begin
            if (a == 21) send_byte(192, 0);
            fetch(a);
            send_byte(int'(rom[a]), 1);
            if (a == 11) g = last_hi;
        end
        fd = t;
        if (t <= cut) q_fd.push_back(t);
    endfunction

    // r: cycle of the last reset-high edge; upd: refresh cycles before UPDATE
    function automatic void model_run(input int r, input int upd,
                                      output int fd1, output int fd2,
                                      output int fd3, output int g3);
        int g;
        t = r + PW;
        nib1(3, I1);
        nib1(3, I2);
        nib1(3, CC);
        nib1(2, CC);
        for (int a = 0; a <= 4; a++) begin
            fetch(a);
            if (rom[a] == 8'h00) t += CL;
            else send_byte(int'(rom[a]), 0);
        end
        if (t <= cut) q_id.push_back(t);
        frame(fd1, g);
        t = fd1 + RF;
        frame(fd2, g);
        t = fd2 + upd + 1;
        frame(fd3, g3);
    endfunction

    logic       e_prev = 1'b0;
    logic       id_prev = 1'b0;
    logic [3:0] db_prev = 4'h0;
    logic       rs_prev = 1'b0;
    int         e_len = 0;
    int         en_cnt = 0;

    always @(negedge clk) begin
        ev_t ev;
        chk("rw_low", int'(LCD_RW), 0);
        chk("sf_ce0_high", int'(SF_CE0), 1);
        chk("rom_addr_max", int'(ROM_ADDR <= 11'd36), 1);
        if (LCD_E && e_prev) begin
            chk("db_stable", int'(LCD_DB), int'(db_prev));
            chk("rs_stable", int'(LCD_RS), int'(rs_prev));
        end
        if (LCD_E && !e_prev) begin
            if (q_e.size() == 0) begin
                chk("e_unexpected", cyc, -1);
            end else begin
                ev = q_e.pop_front();
                chk("e_rise_cycle", cyc, ev.c);
                chk("e_nibble", int'(LCD_DB), ev.v);
                chk("e_rs", int'(LCD_RS), ev.rs);
            end
        end
        if (!LCD_E && e_prev && !RESET) chk("e_width", e_len, EC);
        if (ROM_EN) begin
            en_cnt <= en_cnt + 1;
            if (q_f.size() == 0) begin
                chk("fetch_unexpected", cyc, -1);
            end else begin
                ev = q_f.pop_front();
                chk("fetch_cycle", cyc, ev.c);
                chk("fetch_addr", int'(ROM_ADDR), ev.v);
            end
        end
        if (INIT_DONE && !id_prev) begin
            if (q_id.size() == 0) chk("init_done_unexpected", cyc, -1);
            else chk("init_done_cycle", cyc, q_id.pop_front());
        end
        if (FRAME_DONE) begin
            if (q_fd.size() == 0) chk("frame_done_unexpected", cyc, -1);
            else chk("frame_done_cycle", cyc, q_fd.pop_front());
        end
        e_len   <= LCD_E ? e_len + 1 : 0;
        e_prev  <= LCD_E;
        id_prev <= INIT_DONE;
        db_prev <= LCD_DB;
        rs_prev <= LCD_RS;
    end

    task automatic wait_cyc(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        @(negedge clk);
        UPDATE = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_en"}, int'(ROM_EN), 0);
        chk({tag, "_lcd_e"}, int'(LCD_E), 0);
        chk({tag, "_lcd_db"}, int'(LCD_DB), 0);
        chk({tag, "_lcd_rs"}, int'(LCD_RS), 0);
        chk({tag, "_init_done"}, int'(INIT_DONE), 0);
        chk({tag, "_frame_done"}, int'(FRAME_DONE), 0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_pending_e"}, q_e.size(), 0);
        chk({tag, "_pending_fetch"}, q_f.size(), 0);
        chk({tag, "_pending_init_done"}, q_id.size(), 0);
        chk({tag, "_pending_frame_done"}, q_fd.size(), 0);
        q_e.delete();
        q_f.delete();
        q_id.delete();
        q_fd.delete();
    endtask

    initial begin
        string s1, s2;
        int r, fd1, fd2, fd3, g3, rst_c, base, upd, junk;
        RESET  = 1'b1;
        UPDATE = 1'b0;
        s1 = "ABCDEFGHIJKLMNOP";
        s2 = "abcdefghijklmnop";
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0] = 8'h28; rom[1] = 8'h06; rom[2] = 8'h0C;
        rom[3] = 8'h01; rom[4] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rom[5 + i]  = s1[i];
            rom[21 + i] = s2[i];
        end
        repeat ($urandom_range(3, 6)) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_rom_addr", int'(ROM_ADDR), 0);

        r = cyc;
        RESET = 1'b0;
        base = en_cnt;
        cut = -1;
        model_run(r, 10, fd1, fd2, fd3, g3);
        rst_c = g3 + $urandom_range(0, EC - 1);
        cut = rst_c;
        model_run(r, 10, fd1, fd2, fd3, g3);
        wait_cyc(r + 30);
        pulse_update();
        wait_cyc(fd1 + 1);
        chk("rom_en_cycles_run1", en_cnt - base, 37);
        wait_cyc(fd2 + 10);
        pulse_update();
        wait_cyc(rst_c);
        chk("lcd_e_high_before_abort", int'(LCD_E), 1);
        RESET = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        check_drained("run1");

        for (int i = 5; i <= 36; i++) rom[i] = 8'($urandom_range(0, 255));
        repeat ($urandom_range(1, 4)) @(negedge clk);
        r = cyc;
        RESET = 1'b0;
        base = en_cnt;
        upd = $urandom_range(0, 90);
        cut = -1;
        model_run(r, upd, fd1, fd2, fd3, g3);
        cut = fd3 + 2;
        model_run(r, upd, fd1, fd2, fd3, g3);
        junk = fd1 - $urandom_range(20, 400);
        wait_cyc(junk);
        pulse_update();
        wait_cyc(fd1 + 1);
        chk("rom_en_cycles_run2", en_cnt - base, 37);
        wait_cyc(fd2 + upd);
        pulse_update();
        wait_cyc(cut + 3);
        chk("init_done_held", int'(INIT_DONE), 1);
        check_drained("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
